// File: rtl/axi_lite_regbank_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes,
// channel state encodings and the byte-lane merge helper.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_COMMIT = 2'd1,
        WR_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Sized for the widest supported bus; narrower callers zero-extend
    function automatic logic [63:0] byte_merge(input logic [63:0] old,
                                               input logic [63:0] data,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = data[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_regbank_rd_chan.sv
// Read channel: address decode and registered RDATA/RRESP with a one-cycle
// turnaround; purely observes register contents and hardware status.
module axi_lite_rd_chan
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = 8'b0010_0000
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status
);
    localparam int BL    = $clog2(DATA_WIDTH/8);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    rd_state_t             state_r, state_s;
    logic                  arready_r, arready_s;
    logic                  rvalid_r, rvalid_s;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
    logic [1:0]            rresp_r, rresp_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] rw_word_s, ro_word_s;

    // Address decode and word selection
    always_comb begin
        idx_s     = araddr[BL +: IDX_W];
        hit_s     = (araddr < ADDR_WIDTH'(NUM_REGS * (DATA_WIDTH/8)));
        rw_word_s = '0;
        ro_word_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_s == IDX_W'(i)) begin
                rw_word_s = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
                ro_word_s = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                rw_word_s = rw_word_s;
                ro_word_s = ro_word_s;
            end
        end
    end

    // Read FSM next state and response payload
    always_comb begin
        state_s = state_r;
        rvalid_s = rvalid_r;
        rdata_s  = rdata_r;
        rresp_s  = rresp_r;
        case (state_r)
            RD_IDLE: begin
                if (arready_r && arvalid) begin
                    rvalid_s = 1'b1;
                    state_s  = RD_DATA;
                    if (!hit_s) begin
                        rdata_s = '0;
                        rresp_s = RESP_DECERR;
                    end else if (RO_MASK[idx_s]) begin
                        rdata_s = ro_word_s;
                        rresp_s = RESP_OKAY;
                    end else begin
                        rdata_s = rw_word_s;
                        rresp_s = RESP_OKAY;
                    end
                end else begin
                    state_s = RD_IDLE;
                end
            end
            RD_DATA: begin
                if (rready) begin
                    rvalid_s = 1'b0;
                    state_s  = RD_IDLE;
                end else begin
                    state_s = RD_DATA;
                end
            end
            default: begin
                rvalid_s = 1'b0;
                state_s  = RD_IDLE;
            end
        endcase
        arready_s = (state_s == RD_IDLE);
    end

    // Read channel registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r   <= RD_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= 2'b00;
        end else begin
            state_r   <= state_s;
            arready_r <= arready_s;
            rvalid_r  <= rvalid_s;
            rdata_r   <= rdata_s;
            rresp_r   <= rresp_s;
        end
    end

    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: independent AW/W capture, byte-strobed commit,
// read-only status slots and a start strobe from register 0 bit 0.
module axi_lite_regbank
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = 8'b0010_0000,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = {NUM_REGS*DATA_WIDTH{1'b0}}
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    axi_lite_if.slave                      axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
    output logic                           start_pulse
);
    localparam int STRB_W = DATA_WIDTH/8;
    localparam int BL     = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    wr_state_t             state_r, state_s;
    logic                  aw_held_r, aw_held_s, w_held_r, w_held_s;
    logic                  awready_r, awready_s, wready_r, wready_s;
    logic                  bvalid_r, bvalid_s, start_r, start_s, wr_en_s;
    logic [1:0]            bresp_r, bresp_s;
    logic [ADDR_WIDTH-1:0] awaddr_r, awaddr_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic [STRB_W-1:0]     wstrb_r, wstrb_s;
    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [IDX_W-1:0]      idx_s;
    logic                  hit_s;
    logic [63:0]           old64_s, data64_s, merged64_s;
    logic [7:0]            strb64_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic                  unused_merge_s;

    // Decode of the held address and byte-lane merge against the target word
    always_comb begin
        idx_s    = awaddr_r[BL +: IDX_W];
        hit_s    = (awaddr_r < ADDR_WIDTH'(NUM_REGS * STRB_W));
        old64_s  = '0;
        data64_s = '0;
        strb64_s = '0;
        old64_s[DATA_WIDTH-1:0]  = regs_r[idx_s];
        data64_s[DATA_WIDTH-1:0] = wdata_r;
        strb64_s[STRB_W-1:0]     = wstrb_r;
        merged64_s     = byte_merge(old64_s, data64_s, strb64_s);
        merged_s       = merged64_s[DATA_WIDTH-1:0];
        unused_merge_s = ^merged64_s;
    end

    // Write FSM next state, held payload and response
    always_comb begin
        state_s   = state_r;
        aw_held_s = aw_held_r;
        w_held_s  = w_held_r;
        awaddr_s  = awaddr_r;
        wdata_s   = wdata_r;
        wstrb_s   = wstrb_r;
        bresp_s   = bresp_r;
        bvalid_s  = bvalid_r;
        start_s   = 1'b0;
        wr_en_s   = 1'b0;
        case (state_r)
            WR_IDLE: begin
                if (awready_r && axi.AWVALID) begin
                    aw_held_s = 1'b1;
                    awaddr_s  = axi.AWADDR;
                end else begin
                    aw_held_s = aw_held_r;
                end
                if (wready_r && axi.WVALID) begin
                    w_held_s = 1'b1;
                    wdata_s  = axi.WDATA;
                    wstrb_s  = axi.WSTRB;
                end else begin
                    w_held_s = w_held_r;
                end
                if (aw_held_s && w_held_s) begin
                    state_s = WR_COMMIT;
                end else begin
                    state_s = WR_IDLE;
                end
            end
            WR_COMMIT: begin
                if (!hit_s) begin
                    bresp_s = RESP_DECERR;
                end else if (RO_MASK[idx_s]) begin
                    bresp_s = RESP_SLVERR;
                end else begin
                    bresp_s = RESP_OKAY;
                    wr_en_s = 1'b1;
                    start_s = (idx_s == IDX_W'(0)) && wstrb_r[0] && wdata_r[0];
                end
                bvalid_s = 1'b1;
                state_s  = WR_RESP;
            end
            WR_RESP: begin
                if (axi.BREADY) begin
                    bvalid_s  = 1'b0;
                    aw_held_s = 1'b0;
                    w_held_s  = 1'b0;
                    state_s   = WR_IDLE;
                end else begin
                    state_s = WR_RESP;
                end
            end
            default: begin
                bvalid_s  = 1'b0;
                aw_held_s = 1'b0;
                w_held_s  = 1'b0;
                state_s   = WR_IDLE;
            end
        endcase
        awready_s = (state_s == WR_IDLE) && !aw_held_s;
        wready_s  = (state_s == WR_IDLE) && !w_held_s;
    end

    // Write channel registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r   <= WR_IDLE;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            awaddr_r  <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            bresp_r   <= 2'b00;
            bvalid_r  <= 1'b0;
            start_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            aw_held_r <= aw_held_s;
            w_held_r  <= w_held_s;
            awready_r <= awready_s;
            wready_r  <= wready_s;
            awaddr_r  <= awaddr_s;
            wdata_r   <= wdata_s;
            wstrb_r   <= wstrb_s;
            bresp_r   <= bresp_s;
            bvalid_r  <= bvalid_s;
            start_r   <= start_s;
        end
    end

    // Register array; register 0 bit 0 is a strobe and never stored
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s && (idx_s == IDX_W'(i))) begin
                    regs_r[i] <= (i == 0) ? {merged_s[DATA_WIDTH-1:1], 1'b0} : merged_s;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Export register image; RO slots are owned by hardware and read 0 here
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i]) begin
                reg_out[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else begin
                reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_r[i];
            end
        end
        reg_out[0] = 1'b0;
    end

    assign axi.AWREADY = awready_r;
    assign axi.WREADY  = wready_r;
    assign axi.BVALID  = bvalid_r;
    assign axi.BRESP   = bresp_r;
    assign start_pulse = start_r;

    axi_lite_rd_chan #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_rd_chan (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .araddr    (axi.ARADDR),
        .arvalid   (axi.ARVALID),
        .arready   (axi.ARREADY),
        .rdata     (axi.RDATA),
        .rresp     (axi.RRESP),
        .rvalid    (axi.RVALID),
        .rready    (axi.RREADY),
        .reg_out   (reg_out),
        .hw_status (hw_status)
    );

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; next-generation control/status interface for the dot-product accelerator and later accelerators.
- Register count, reset values and per-register read-only selection are set by parameters.
- AW and W are accepted independently in either order; WSTRB byte lanes and RRESP are supported, with OKAY/SLVERR/DECERR responses.
- Exports all register contents to the datapath and emits a one-cycle start pulse.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- NUM_REGS, 8, number of word registers; must be ≥1.
- RO_MASK, 8'b0010_0000, bit i=1 makes register i read-only, sourced from hw_status.
- RESET_VALUES, {NUM_REGS*DATA_WIDTH{1'b0}}, flat reset image; register i is slice i.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte write enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- reg_out  out  NUM_REGS*DATA_WIDTH  current register contents; RO slots read 0.
- hw_status  in  NUM_REGS*DATA_WIDTH  values returned for RO registers.
- start_pulse  out  1  one-cycle start strobe.

Behaviour:
- Clock is ACLK. Reset is ARESETN, asynchronous, active-low.
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID and start_pulse are 0; BRESP, RRESP and RDATA are 0; registers take RESET_VALUES.
- Reset mid-transaction discards any held address/data and any pending response.
- Decode: index = addr[$clog2(NUM_REGS)+BL-1:BL], where BL = log2(DATA_WIDTH/8). addr[BL-1:0] is ignored. Any address ≥ NUM_REGS*DATA_WIDTH/8 is a decode miss.

Write channel:
- States: WR_IDLE, WR_COMMIT, WR_RESP.
- In WR_IDLE, AWREADY = 1 while no address is held; WREADY = 1 while no data is held. Each handshake latches its payload independently; order is free, and same-cycle handshakes are allowed.
- When both are held, go to WR_COMMIT (1 cycle) with AWREADY = WREADY = 0.
- WR_COMMIT:
  - Decode miss: BRESP = DECERR (2'b11), no write.
  - Read-only index: BRESP = SLVERR (2'b10), no write.
  - Otherwise: BRESP = OKAY and bytes are written where WSTRB = 1. All-zero WSTRB gives OKAY with no change.
  - Then go to WR_RESP with BVALID = 1.
- WR_RESP: hold BVALID and BRESP until BREADY; then clear BVALID, clear the held flags and return to WR_IDLE.
- Throughput: at most one write every 3 cycles.
- Latency: last AW/W handshake to BVALID = 2 cycles.

Start pulse:
- An OKAY write to register 0 with WSTRB[0] = 1 and WDATA[0] = 1 asserts start_pulse for exactly the one cycle after WR_COMMIT.
- Register 0 bit 0 is self-clearing and always reads back 0.

Read channel:
- States: RD_IDLE, RD_DATA.
- ARREADY = 1 only in RD_IDLE. On handshake, the next cycle has RVALID = 1 with registered RDATA/RRESP:
  - RW register: its value, OKAY.
  - RO register: its hw_status slice, OKAY.
  - Decode miss: RDATA 0, RRESP DECERR.
- Hold RDATA/RRESP/RVALID until RREADY, then return to RD_IDLE.
- Latency: 1 cycle. Read and write channels are fully concurrent.
- Read and WR_COMMIT to the same register on the same edge: the read returns the pre-write value.
- The read path never modifies state.

Decomposition:
- Package axi_lite_pkg holds:
  - Response constants RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - Enums wr_state_t and rd_state_t.
  - Function byte_merge(old, data, strb).
- Top-level axi_lite_regbank holds the write FSM, the register array and start_pulse.
- One sub-module, axi_lite_rd_chan, holds the read FSM, decode and response registers. It is fed by reg_out and hw_status.

Test Plan:
1. Reset with default parameters, then read all 8 registers -> each matches its RESET_VALUES slice with OKAY; register 5 returns hw_status[191:160]. Read 0x20 -> RDATA 0, RRESP 2'b11.
2. W handshake 3 cycles before AW: addr 0x08, data 0xA5A5_A5A5, WSTRB 4'b0101 -> BVALID 2 cycles after AW, BRESP OKAY; read of 0x08 gives 0x00A5_00A5.
3. Write to 0x14 (RO) -> BRESP 2'b10, register unchanged. Hold BREADY low 5 cycles -> BVALID and BRESP stable, AWREADY 0 throughout.
4. Write 0x0000_0003 to 0x00 -> start_pulse high exactly 1 cycle; read of 0x00 returns 0x0000_0002.
5. Same-cycle AW/W to 0x04 with data 0x1234, plus AR to 0x04 timed to coincide with WR_COMMIT -> read returns old value; next read returns 0x1234.
6. ARESETN low while BVALID = 1 and a held AW is pending -> BVALID and RVALID go 0 immediately and registers reload; the first post-reset write completes normally.
